dmem_line_adapter: RTL
======================

// Module: dmem_line_adapter
// PURPOSE
//  Data-side memory adapter directly downstream of the pipeline stall unit. It consumes the unit's
//  word-granular mem_read/mem_write/mem_address/line_offset requests and turns them into 128-bit
//  Wishbone line transactions. It returns mem_resp and mem_rdata to the stall unit.
//  A one-line read buffer answers repeated reads to the same line without a bus cycle.
//  This covers the LDI/STI back-to-back access pattern.
// PARAMETERS
//  LINE_WIDTH   128  bits per Wishbone line (8 x 16-bit words)
//  LADDR_WIDTH  12   line address width (byte address [15:4])
//  BUF_ENABLE   1    1 = line buffer active; 0 = every read misses
// PORTS
//  clk              in   1    clock; all logic on posedge
//  rst_n            in   1    reset, asynchronous assert, active-low
//  mem_read         in   1    read request, held high until mem_resp
//  mem_write        in   1    write request, held high until mem_resp
//  mem_address      in   12   line address of the access
//  line_offset      in   4    byte offset in line; [3:1] = word select
//  mem_byte_enable  in   2    write byte lanes of the word ([0] low byte, [1] high byte)
//  mem_wdata        in   16   write data
//  mem_resp         out  1    one-cycle completion pulse
//  mem_rdata        out  16   read word; registered, valid from mem_resp until the next mem_resp
//  wb_cyc, wb_stb   out  1    Wishbone cycle/strobe (driven identically)
//  wb_we            out  1    1 = write transaction
//  wb_adr           out  12   line address
//  wb_sel           out  16   byte selects
//  wb_dat_o         out  128  write line: mem_wdata replicated in all 8 word lanes
//  wb_dat_i         in   128  read line
//  wb_ack           in   1    transaction complete; sampled only while wb_stb=1
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; buf_valid=0. Outputs mem_resp, wb_cyc, wb_stb, wb_we,
//   wb_sel and mem_rdata all =0. If reset arrives mid-transaction, wb_cyc/wb_stb drop at once
//   and no mem_resp is generated.
//  Request acceptance: only in IDLE. Address, offset, byte_enable, wdata and kind are latched at
//   the accepting edge, and the rest of the transaction uses only the latched copy.
//  If mem_read and mem_write are both high, the request is a write.
//  If the request is withdrawn after acceptance (pipeline flush), the transaction still
//   completes and mem_resp still pulses. The requester ignores that pulse.
//  FSM states and transitions:
//   IDLE     read and buf hit (BUF_ENABLE & buf_valid & buf_tag==mem_address) -> RESP
//            read miss -> RD_BUS; write -> WR_BUS; no request -> stay in IDLE
//   RD_BUS   wb_cyc=wb_stb=1, wb_we=0, wb_sel=16'hFFFF. On wb_ack: buf_line<=wb_dat_i,
//            buf_tag<=latched addr, buf_valid<=1, then -> RESP
//   WR_BUS   wb_cyc=wb_stb=1, wb_we=1, wb_sel = {14'b0,be} << (2*off[3:1]).
//            On wb_ack: if buf_valid and the tag matches, merge the enabled bytes into buf_line;
//            then -> RESP
//   RESP     mem_resp=1 for exactly this cycle. For reads, mem_rdata <= buf_line word off[3:1]
//            (loaded at the RESP entry edge). Then -> IDLE
//  Latency from the accepting edge N: read hit gives mem_resp in cycle N+1. A miss or write with
//   wb_ack in cycle M gives mem_resp in cycle M+1. mem_resp is never high two cycles in a row,
//   so a held request is re-accepted at the earliest in the cycle after RESP.
//  wb_stb stays high until wb_ack; the Wishbone outputs do not change while a transaction is
//   pending. wb_ack is ignored outside RD_BUS/WR_BUS.
//  A write with be=2'b00 still runs a bus cycle with wb_sel=0 and still returns mem_resp.
// TESTING
//  1 Read miss: addr=12'h0A3, off=4'h6, wb_ack after 3 cycles with wb_dat_i word3=16'hBEEF
//    -> wb_sel=16'hFFFF, wb_adr=12'h0A3; 1-cycle mem_resp, mem_rdata=16'hBEEF
//  2 Read hit: repeat addr=12'h0A3 with off=4'h0 -> no wb_stb, mem_resp 1 cycle after acceptance,
//    mem_rdata = word0 of the buffered line
//  3 Write, byte/lane shifting: addr=12'h0A3, off=4'h4, be=2'b10, wdata=16'h12xx, ack
//    -> wb_we=1, wb_sel=16'h0020; the next read of word2 hits with high byte=8'h12
//  4 LDI pattern: read 12'h010, then an immediately held read of 12'h200
//    -> two separate mem_resp pulses with at least 1 cycle between them; the second is a miss
//  5 Reset mid-RD_BUS: drop rst_n before ack -> wb_cyc=0 immediately, no mem_resp, buf_valid=0;
//    a repeat read misses
//  6 Both read and write high plus withdrawal: write wins; request dropped after acceptance
//    -> bus cycle completes and mem_resp pulses once

Source files
------------

// File: rtl/dmem_line_adapter.sv
// Data-side adapter: turns word-granular stall-unit requests into 128-bit Wishbone line
// transactions, with a one-line read buffer that answers repeated reads of the same line.
module dmem_line_adapter #(
   parameter int LINE_WIDTH  = 128,
   parameter int LADDR_WIDTH = 12,
   parameter bit BUF_ENABLE  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [LADDR_WIDTH-1:0] mem_address,
   input  logic [3:0]             line_offset,
   input  logic [1:0]             mem_byte_enable,
   input  logic [15:0]            mem_wdata,
   output logic                   mem_resp,
   output logic [15:0]            mem_rdata,
   output logic                   wb_cyc,
   output logic                   wb_stb,
   output logic                   wb_we,
   output logic [LADDR_WIDTH-1:0] wb_adr,
   output logic [LINE_WIDTH/8-1:0] wb_sel,
   output logic [LINE_WIDTH-1:0]  wb_dat_o,
   input  logic [LINE_WIDTH-1:0]  wb_dat_i,
   input  logic                   wb_ack
);

   localparam int WORDS = LINE_WIDTH / 16;
   localparam int BYTES = LINE_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, RD_BUS, WR_BUS, RESP} state_t;

   state_t                 state;
   logic [2:0]             lat_word;
   logic                   buf_valid;
   logic [LADDR_WIDTH-1:0] buf_tag;
   logic [LINE_WIDTH-1:0]  buf_line;
   logic                   buf_hit;
   logic                   unused_offset_lsb;

   assign buf_hit           = BUF_ENABLE && buf_valid && (buf_tag == mem_address);
   assign unused_offset_lsb = line_offset[0];

   // The registered Wishbone outputs double as the latched copy of the request, so the
   // write merge into the buffer reuses wb_sel/wb_dat_o rather than separate registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_word  <= '0;
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_line  <= '0;
         mem_resp  <= 1'b0;
         mem_rdata <= '0;
         wb_cyc    <= 1'b0;
         wb_stb    <= 1'b0;
         wb_we     <= 1'b0;
         wb_adr    <= '0;
         wb_sel    <= '0;
         wb_dat_o  <= '0;
      end else begin
         mem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_write) begin
                  lat_word <= line_offset[3:1];
                  wb_adr   <= mem_address;
                  wb_cyc   <= 1'b1;
                  wb_stb   <= 1'b1;
                  wb_we    <= 1'b1;
                  wb_sel   <= {{(BYTES-2){1'b0}}, mem_byte_enable} << {line_offset[3:1], 1'b0};
                  wb_dat_o <= {WORDS{mem_wdata}};
                  state    <= WR_BUS;
               end else if (mem_read && buf_hit) begin
                  mem_resp  <= 1'b1;
                  mem_rdata <= buf_line[{line_offset[3:1], 4'b0000} +: 16];
                  state     <= RESP;
               end else if (mem_read) begin
                  lat_word <= line_offset[3:1];
                  wb_adr   <= mem_address;
                  wb_cyc   <= 1'b1;
                  wb_stb   <= 1'b1;
                  wb_we    <= 1'b0;
                  wb_sel   <= '1;
                  state    <= RD_BUS;
               end
            end
            RD_BUS: begin
               if (wb_ack) begin
                  buf_line  <= wb_dat_i;
                  buf_tag   <= wb_adr;
                  buf_valid <= 1'b1;
                  mem_rdata <= wb_dat_i[{lat_word, 4'b0000} +: 16];
                  mem_resp  <= 1'b1;
                  wb_cyc    <= 1'b0;
                  wb_stb    <= 1'b0;
                  wb_sel    <= '0;
                  state     <= RESP;
               end
            end
            WR_BUS: begin
               if (wb_ack) begin
                  // Write-through: keep the buffered copy coherent with the bus line.
                  if (buf_valid && (buf_tag == wb_adr)) begin
                     for (int i = 0; i < BYTES; i++) begin
                        if (wb_sel[i]) buf_line[8*i +: 8] <= wb_dat_o[8*i +: 8];
                     end
                  end
                  mem_resp <= 1'b1;
                  wb_cyc   <= 1'b0;
                  wb_stb   <= 1'b0;
                  wb_we    <= 1'b0;
                  wb_sel   <= '0;
                  state    <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
